vram_arbiter: RTL and testbench

//  Shares the single-port synchronous VRAM (16-bit words, 14-bit address)

---
 rtl/vram_arbiter_if.sv | 55 +++++
 rtl/vram_arbiter.sv | 158 +++++++++++++++
 tb/tb_vram_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters (VGA scan-out, CPU)
// and the single-port synchronous VRAM.
interface vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  // VGA scan-out read port
  logic              vga_req;
  logic [ADDR_W-1:0] vga_raddr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;

  // CPU posted-write port
  logic              cpu_wvalid;
  logic              cpu_wready;
  logic [ADDR_W-1:0] cpu_waddr;
  logic [DATA_W-1:0] cpu_wdata;

  // CPU coherent read port
  logic              cpu_rreq;
  logic [ADDR_W-1:0] cpu_raddr;
  logic              cpu_rack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  // VRAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  // The arbiter serves the bus
  modport slave (
    input  vga_req, vga_raddr,
    input  cpu_wvalid, cpu_waddr, cpu_wdata,
    input  cpu_rreq, cpu_raddr,
    input  ram_rdata,
    output vga_rdata, vga_rvalid,
    output cpu_wready,
    output cpu_rack, cpu_rdata, cpu_rvalid,
    output ram_addr, ram_wdata, ram_we
  );

  // Requesters and the RAM drive the other side
  modport master (
    output vga_req, vga_raddr,
    output cpu_wvalid, cpu_waddr, cpu_wdata,
    output cpu_rreq, cpu_raddr,
    output ram_rdata,
    input  vga_rdata, vga_rvalid,
    input  cpu_wready,
    input  cpu_rack, cpu_rdata, cpu_rvalid,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA reads have absolute priority, CPU writes are
// posted through a small FIFO, CPU reads wait until every posted write drained.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  vram_arbiter_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;

  // ---------------------------------------------------------------------
  // Posted-write FIFO state
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             cpu_wready_reg, cpu_wready_next;

  logic [FIFO_DEPTH-1:0][ADDR_W-1:0] entry_addr;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] entry_data;
  logic [ADDR_W-1:0]                 head_addr;
  logic [DATA_W-1:0]                 head_data;

  logic push;
  logic pop;
  logic fifo_empty;

  // ---------------------------------------------------------------------
  // Arbitration and read-owner tag pipeline
  // ---------------------------------------------------------------------
  logic       grant_vga;
  logic       grant_cpu;
  logic [1:0] tag_vga_reg, tag_vga_next;
  logic [1:0] tag_cpu_reg, tag_cpu_next;

  logic [ADDR_W-1:0] ram_addr_reg,  ram_addr_next;
  logic [DATA_W-1:0] ram_wdata_reg, ram_wdata_next;
  logic              ram_we_reg,    ram_we_next;

  assign push       = bus.cpu_wvalid & cpu_wready_reg;
  assign fifo_empty = (level_reg == '0);

  // A CPU read must also not re-issue in the cycle its rack is showing,
  // because the requester is still holding cpu_rreq high during that cycle.
  assign grant_vga  = bus.vga_req;
  assign grant_cpu  = !bus.vga_req && bus.cpu_rreq && fifo_empty && !push
                      && !tag_cpu_reg[0];
  assign pop        = !bus.vga_req && !fifo_empty;

  // ---------------------------------------------------------------------
  // FIFO storage: one register pair per entry, no reset needed
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [ADDR_W-1:0] addr_reg;
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          addr_reg <= bus.cpu_waddr;
          data_reg <= bus.cpu_wdata;
        end
      end

      assign entry_addr[gi] = addr_reg;
      assign entry_data[gi] = data_reg;
    end
  endgenerate

  assign head_addr = entry_addr[rd_ptr_reg];
  assign head_data = entry_data[rd_ptr_reg];

  // ---------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    level_next      = level_reg + LVL_W'(push) - LVL_W'(pop);
    cpu_wready_next = (level_next < LVL_W'(FIFO_DEPTH));
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      cpu_wready_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      cpu_wready_reg <= cpu_wready_next;
    end
  end

  // ---------------------------------------------------------------------
  // RAM port and read-owner tags
  // ---------------------------------------------------------------------
  always_comb begin
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    ram_we_next    = 1'b0;
    tag_vga_next   = {tag_vga_reg[0], grant_vga};
    tag_cpu_next   = {tag_cpu_reg[0], grant_cpu};
    if (grant_vga) begin
      ram_addr_next = bus.vga_raddr;
    end else if (grant_cpu) begin
      ram_addr_next = bus.cpu_raddr;
    end else if (pop) begin
      ram_addr_next  = head_addr;
      ram_wdata_next = head_data;
      ram_we_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      ram_we_reg    <= 1'b0;
      tag_vga_reg   <= '0;
      tag_cpu_reg   <= '0;
    end else begin
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      ram_we_reg    <= ram_we_next;
      tag_vga_reg   <= tag_vga_next;
      tag_cpu_reg   <= tag_cpu_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: read data is a straight pass-through, owner tag picks rvalid
  // ---------------------------------------------------------------------
  assign bus.ram_addr   = ram_addr_reg;
  assign bus.ram_wdata  = ram_wdata_reg;
  assign bus.ram_we     = ram_we_reg;
  assign bus.cpu_wready = cpu_wready_reg;
  assign bus.cpu_rack   = tag_cpu_reg[0];
  assign bus.cpu_rvalid = tag_cpu_reg[1];
  assign bus.vga_rvalid = tag_vga_reg[1];
  assign bus.vga_rdata  = bus.ram_rdata;
  assign bus.cpu_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: drivers queue expected reads/writes, a
// negedge monitor pops and compares whenever the DUT shows rvalid or ram_we.
module tb_vram_arbiter;

  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Synchronous single-port RAM, read-before-write, one cycle read latency
  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [DW-1:0] data; int cyc; } rd_exp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;

  rd_exp_t vga_q[$];
  rd_exp_t cpu_q[$];
  wr_exp_t wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Monitor: pops expectations whenever the DUT presents an output
  // ---------------------------------------------------------------------
  rd_exp_t m_vga, m_cpu;
  wr_exp_t m_wr;

  always @(negedge clk) begin
    if (bus.vga_rvalid) begin
      if (vga_q.size() == 0) begin
        check("vga_spurious_rvalid", 32'd1, 32'd0);
      end else begin
        m_vga = vga_q.pop_front();
        check("vga_rdata", 32'(bus.vga_rdata), 32'(m_vga.data));
        check("vga_latency_cyc", cyc, m_vga.cyc);
        $display("[TB] cyc %0d vga read data %h", cyc, bus.vga_rdata);
      end
    end
    if (bus.cpu_rvalid) begin
      if (cpu_q.size() == 0) begin
        check("cpu_spurious_rvalid", 32'd1, 32'd0);
      end else begin
        m_cpu = cpu_q.pop_front();
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu.data));
        check("cpu_rvalid_cyc", cyc, m_cpu.cyc);
        $display("[TB] cyc %0d cpu read data %h", cyc, bus.cpu_rdata);
      end
    end
    if (bus.ram_we) begin
      if (wr_q.size() == 0) begin
        check("ram_we_spurious", 32'd1, 32'd0);
      end else begin
        m_wr = wr_q.pop_front();
        check("ram_waddr", 32'(bus.ram_addr), 32'(m_wr.addr));
        check("ram_wdata", 32'(bus.ram_wdata), 32'(m_wr.data));
        $display("[TB] cyc %0d ram write %h <= %h", cyc, bus.ram_addr, bus.ram_wdata);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Drivers (all called at posedge+1)
  // ---------------------------------------------------------------------
  task automatic vga_read(input logic [AW-1:0] a);
    bus.vga_req   = 1'b1;
    bus.vga_raddr = a;
    vga_q.push_back('{shadow[a], cyc + 2});
    tick();
    bus.vga_req   = 1'b0;
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_wvalid = 1'b1;
    bus.cpu_waddr  = a;
    bus.cpu_wdata  = d;
    for (int i = 0; i < 64; i++) begin
      if (bus.cpu_wready) begin
        wr_q.push_back('{a, d});
        shadow[a] = d;
        tick();
        bus.cpu_wvalid = 1'b0;
        return;
      end
      tick();
    end
    check("cpu_write_timeout", 32'd0, 32'd1);
    bus.cpu_wvalid = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output int rack_cyc);
    bus.cpu_rreq  = 1'b1;
    bus.cpu_raddr = a;
    rack_cyc      = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.cpu_rack) begin
        rack_cyc = cyc;
        cpu_q.push_back('{shadow[a], cyc + 1});
        tick();
        bus.cpu_rreq = 1'b0;
        return;
      end
    end
    check("cpu_rack_timeout", 32'd0, 32'd1);
    tick();
    bus.cpu_rreq = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  int k;
  int rack;
  logic [DW-1:0] saved [3];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = 16'(i) ^ 16'h5A5A;
      shadow[i] = 16'(i) ^ 16'h5A5A;
    end
    mem[14'h0123]    = 16'hBEEF;
    shadow[14'h0123] = 16'hBEEF;

    bus.vga_req    = 1'b0;
    bus.vga_raddr  = '0;
    bus.cpu_wvalid = 1'b0;
    bus.cpu_waddr  = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_rreq   = 1'b0;
    bus.cpu_raddr  = '0;

    // Reset values
    @(negedge clk);
    check("rst_ram_we",     32'(bus.ram_we),     32'd0);
    check("rst_ram_addr",   32'(bus.ram_addr),   32'd0);
    check("rst_ram_wdata",  32'(bus.ram_wdata),  32'd0);
    check("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
    check("rst_cpu_rack",   32'(bus.cpu_rack),   32'd0);
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst_cpu_wready", 32'(bus.cpu_wready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("wready_before_edge", 32'(bus.cpu_wready), 32'd0);
    tick();
    check("wready_after_edge", 32'(bus.cpu_wready), 32'd1);

    // 1: single VGA read, fixed 2-cycle latency
    vga_read(14'h0123);
    repeat (4) tick();

    // 2a: four back-to-back writes, no other traffic; FIFO drains as it fills
    for (int i = 0; i < 4; i++) cpu_write(14'h0010 + 14'(i), 16'h00A0 + 16'(i));
    repeat (4) tick();
    check("t2a_wready_idle", 32'(bus.cpu_wready), 32'd1);

    // 2b: VGA held busy so the FIFO fills; wready drops after the 4th accept
    fork
      for (int i = 0; i < 6; i++) vga_read(14'h0300 + 14'(i));
      begin
        for (int i = 0; i < 4; i++) cpu_write(14'h0020 + 14'(i), 16'h00B0 + 16'(i));
        check("t2b_wready_full", 32'(bus.cpu_wready), 32'd0);
      end
    join
    repeat (2) tick();
    check("t2b_wready_back", 32'(bus.cpu_wready), 32'd1);
    repeat (4) tick();

    // 3: read right after a posted write to the same address
    k = cyc;
    cpu_write(14'h0011, 16'h5555);
    cpu_read(14'h0011, rack);
    check("t3_rack_cyc", rack, k + 3);
    repeat (4) tick();

    // 4: VGA and CPU read in the same cycle
    k = cyc;
    fork
      vga_read(14'h0123);
      cpu_read(14'h0050, rack);
    join
    check("t4_rack_not_early", 32'(rack >= k + 2), 32'd1);
    repeat (4) tick();

    // 5: VGA every 8 cycles against continuous writes
    fork
      for (int i = 0; i < 6; i++) begin
        vga_read(14'h0200 + 14'(i));
        repeat (7) tick();
      end
      for (int i = 0; i < 24; i++) cpu_write(14'h0700 + 14'(i), 16'hC000 + 16'(i));
    join
    cpu_read(14'h0700, rack);
    cpu_read(14'h0717, rack);
    repeat (4) tick();

    // 6: reset with three writes posted and VGA reads in flight
    for (int i = 0; i < 3; i++) saved[i] = shadow[14'h0600 + 14'(i)];
    fork
      for (int i = 0; i < 5; i++) vga_read(14'h0400 + 14'(i));
      for (int i = 0; i < 3; i++) cpu_write(14'h0600 + 14'(i), 16'hD000 + 16'(i));
    join
    rst_n = 1'b0;
    vga_q.delete();
    cpu_q.delete();
    wr_q.delete();
    for (int i = 0; i < 3; i++) shadow[14'h0600 + 14'(i)] = saved[i];
    #1;
    check("t6_ram_we_async", 32'(bus.ram_we), 32'd0);
    check("t6_vga_rvalid_async", 32'(bus.vga_rvalid), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("t6_wready_after", 32'(bus.cpu_wready), 32'd1);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) cpu_read(14'h0600 + 14'(i), rack);
    repeat (6) tick();

    check("end_vga_q_empty", vga_q.size(), 32'd0);
    check("end_cpu_q_empty", cpu_q.size(), 32'd0);
    check("end_wr_q_empty",  wr_q.size(),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
